// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Output-side reader for the IF spiking network. One clk cycle is one
// network timestep. After an accepted start, spikes on every output line are
// counted (saturating) for WINDOW timesteps. A sequential argmax then walks
// the counters one neuron per cycle, and the winner is reported with a
// one-cycle done pulse.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   start      request a new classification (accepted only while idle)
//   spike_in   spike bits from the network output layer, bit i = neuron i
//   busy       high while counting or comparing
//   done       one-cycle pulse when the result registers update
//   class_out  index of the neuron with the highest count (lowest index wins ties)
//   max_count  spike count of the winning neuron
//   no_spike   high if every count was zero in the last window
//   counts_out live counters, neuron i at [i*COUNT_WIDTH +: COUNT_WIDTH]
module spike_rate_decoder #(
    parameter int NUM_OUTPUTS = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int WINDOW      = 100,
    parameter int CLASS_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [NUM_OUTPUTS-1:0]             spike_in,
    output logic                               busy,
    output logic                               done,
    output logic [CLASS_WIDTH-1:0]             class_out,
    output logic [COUNT_WIDTH-1:0]             max_count,
    output logic                               no_spike,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] counts_out
);

    // The window counter only needs to reach WINDOW-1.
    localparam int WIN_WIDTH = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_WIDTH-1:0]   WIN_LAST = WIN_WIDTH'(WINDOW - 1);
    localparam logic [CLASS_WIDTH-1:0] IDX_LAST = CLASS_WIDTH'(NUM_OUTPUTS - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_COMPARE = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [COUNT_WIDTH-1:0]   count_r [NUM_OUTPUTS];
    logic [WIN_WIDTH-1:0]     win_cnt_r;
    logic [CLASS_WIDTH-1:0]   idx_r;
    logic [CLASS_WIDTH-1:0]   best_idx_r;
    logic [COUNT_WIDTH-1:0]   best_cnt_r;
    logic                     busy_r;
    logic                     done_r;
    logic [CLASS_WIDTH-1:0]   class_r;
    logic [COUNT_WIDTH-1:0]   max_r;
    logic                     no_spike_r;

    logic                     win_last_s;
    logic                     idx_last_s;
    logic [COUNT_WIDTH-1:0]   cur_cnt_s;
    logic [CLASS_WIDTH-1:0]   cand_idx_s;
    logic [COUNT_WIDTH-1:0]   cand_cnt_s;

    // Argmax step and terminal-count decodes.
    always_comb begin
        win_last_s = (win_cnt_r == WIN_LAST);
        idx_last_s = (idx_r == IDX_LAST);
        cur_cnt_s  = count_r[idx_r];
        // Strict greater-than keeps the earlier (lower) index on ties.
        if (cur_cnt_s > best_cnt_r) begin
            cand_idx_s = idx_r;
            cand_cnt_s = cur_cnt_s;
        end else begin
            cand_idx_s = best_idx_r;
            cand_cnt_s = best_cnt_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_COUNT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (win_last_s) begin
                    state_next_s = ST_COMPARE;
                end else begin
                    state_next_s = ST_COUNT;
                end
            end
            ST_COMPARE: begin
                if (idx_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_COMPARE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-neuron saturating spike counters; cleared on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                count_r[i] <= {COUNT_WIDTH{1'b0}};
            end
        end else if (state_r == ST_IDLE && start) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                count_r[i] <= {COUNT_WIDTH{1'b0}};
            end
        end else if (state_r == ST_COUNT) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if (spike_in[i] && (count_r[i] != CNT_MAX)) begin
                    count_r[i] <= count_r[i] + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Window counter, argmax walk, status flags and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_r  <= {WIN_WIDTH{1'b0}};
            idx_r      <= {CLASS_WIDTH{1'b0}};
            best_idx_r <= {CLASS_WIDTH{1'b0}};
            best_cnt_r <= {COUNT_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            class_r    <= {CLASS_WIDTH{1'b0}};
            max_r      <= {COUNT_WIDTH{1'b0}};
            no_spike_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        win_cnt_r <= {WIN_WIDTH{1'b0}};
                        busy_r    <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    win_cnt_r <= win_cnt_r + {{(WIN_WIDTH-1){1'b0}}, 1'b1};
                    if (win_last_s) begin
                        idx_r      <= {CLASS_WIDTH{1'b0}};
                        best_idx_r <= {CLASS_WIDTH{1'b0}};
                        best_cnt_r <= {COUNT_WIDTH{1'b0}};
                    end
                end
                ST_COMPARE: begin
                    best_idx_r <= cand_idx_s;
                    best_cnt_r <= cand_cnt_s;
                    if (idx_last_s) begin
                        // All-zero counts leave cand_idx_s at 0 already, but
                        // force it so class_out is 0 whenever no_spike is set.
                        class_r    <= (cand_cnt_s == {COUNT_WIDTH{1'b0}}) ?
                                      {CLASS_WIDTH{1'b0}} : cand_idx_s;
                        max_r      <= cand_cnt_s;
                        no_spike_r <= (cand_cnt_s == {COUNT_WIDTH{1'b0}});
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        idx_r <= idx_r + {{(CLASS_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            counts_out[i*COUNT_WIDTH +: COUNT_WIDTH] = count_r[i];
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign class_out = class_r;
    assign max_count = max_r;
    assign no_spike  = no_spike_r;

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Output-side reader for the IF spiking network.
- Counts spikes on each output-neuron line over a fixed window of timesteps, then picks the winning class by sequential argmax.
- Reports the winner with a one-cycle done pulse.
- Sits between the network's spike_out bus and the classification/readout logic. One clk cycle is one network timestep.

Parameters:
- NUM_OUTPUTS, 4, number of spike lines (output neurons/classes); must be ≥ 1.
- COUNT_WIDTH, 8, width of each per-neuron spike counter (saturating).
- WINDOW, 100, number of timesteps counted per classification; must be ≥ 1.
- CLASS_WIDTH, derived = max(1, $clog2(NUM_OUTPUTS)), width of class index.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new classification; accepted only in IDLE
- spike_in  input  NUM_OUTPUTS  spike bits from network output layer, bit i = neuron i
- busy  output  1  high while in COUNT or COMPARE
- done  output  1  one-cycle pulse when result registers update
- class_out  output  CLASS_WIDTH  index of neuron with highest count
- max_count  output  COUNT_WIDTH  spike count of winning neuron
- no_spike  output  1  high if every count was zero in last window
- counts_out  output  NUM_OUTPUTS*COUNT_WIDTH  live counters, neuron i at bits [i*COUNT_WIDTH +: COUNT_WIDTH]

Behaviour:
- Reset is asynchronous and active-high. On rst:
  - state = IDLE
  - all counters, window counter and compare index = 0
  - busy, done, class_out, max_count, no_spike = 0
  - Reset mid-operation aborts immediately; no done is produced.
- States: IDLE, COUNT, COMPARE. Unused encodings return to IDLE.
- IDLE:
  - start=1 at edge E0 → clear all counters and the window counter; go to COUNT.
  - spike_in at E0 is not counted.
  - Result outputs keep their previous values.
- COUNT (edges E1..E_WINDOW):
  - Each edge: for every i with spike_in[i]=1, count[i] += 1, saturating at 2^COUNT_WIDTH−1 (no wrap).
  - Window counter increments each edge. On the edge that samples the WINDOW-th timestep (E_WINDOW), go to COMPARE with idx=0, running best_idx=0, best_cnt=0.
  - start is ignored.
- COMPARE (edges E_WINDOW+1..E_WINDOW+NUM_OUTPUTS):
  - One neuron per edge: if count[idx] > best_cnt (strict), best_idx=idx and best_cnt=count[idx]. Ties resolve to the lowest index.
  - On the edge evaluating idx=NUM_OUTPUTS−1, register the results into the outputs:
    - class_out = final best_idx, max_count = final best_cnt
    - no_spike = (final best_cnt == 0); class_out = 0 in that case
    - done = 1; return to IDLE.
  - spike_in is ignored; counters hold their values.
- done is high for exactly the one cycle after E_WINDOW+NUM_OUTPUTS, then cleared.
- busy is a registered signal:
  - It is 1 from after E0 through the cycle before done, and 0 in the done cycle.
- start high during the done cycle is accepted, since the block is in IDLE. A new window begins on that edge.
- counts_out reflects live counter registers in all states. It holds until the next accepted start clears it.
- Total latency is start edge to done assertion = WINDOW+NUM_OUTPUTS edges.

Test Plan:
1. Reset: assert rst asynchronously between edges → all outputs 0 immediately, state IDLE.
2. Single winner (NUM_OUTPUTS=4, COUNT_WIDTH=4, WINDOW=10):
   - Stimulus: start, then spike_in=4'b0100 for 10 cycles.
   - Required: counts_out = {0,10,0,0}, i.e. count[2]=10.
   - done 14 edges after start edge, class_out=2, max_count=10, no_spike=0, busy falls as done rises.
3. Tie, same config: neurons 1 and 3 each spike 5 times, neuron 0 spikes 4 times → class_out=1, max_count=5.
4. Silence: spike_in=0 all window → no_spike=1, class_out=0, max_count=0, done still pulses at edge 14.
5. Saturation (COUNT_WIDTH=3, WINDOW=10):
   - Stimulus: bit0 constant 1; bit3 spikes 7 times.
   - Required: both counts = 7 with no wrap, class_out=0.
6. Protocol and reset:
   - start pulses during COUNT/COMPARE → ignored, single done.
   - start in the done cycle → new window, counters cleared.
   - rst mid-COUNT → busy=0 at once, no done; next start runs a full 10-cycle window.
